sat_lane_accum: RTL and testbench
=================================

Name: sat_lane_accum

Overview:
- Downstream of the packed 4x4-bit saturating lane adder in the execute path.
- Accumulates a stream of packed 16-bit lane words over a programmed length, lane by lane, with signed 4-bit saturation.
- Returns the packed total to writeback through a valid/ready handshake.
- Serves reduction-style instructions that sum several packed words without a register-file round-trip per word.

Parameters:
- LANES, 4, number of sub-word lanes.
- LANE_W, 4, lane width in bits (signed two's complement).
- CNT_W, 4, width of the length/remaining counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  begin a new accumulation job; sampled only in IDLE.
- len  in  CNT_W  number of words in the job; sampled with start.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  LANES*LANE_W  packed lane word; lane i = bits [i*LANE_W +: LANE_W].
- out_valid  out  1  accumulated result available.
- out_ready  in  1  writeback consumes the result.
- out_data  out  LANES*LANE_W  packed accumulated result.
- sat_flags  out  LANES  sticky per-lane saturation; bit i = lane i.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, ACCUM, DONE, held in a registered state variable.
- Reset (rst_n low, asynchronous): state = IDLE; acc = 0; remaining = 0; sat_flags = 0; out_valid = 0; in_ready = 0; busy = 0; out_data = 0.
- IDLE:
  - in_ready = 0, out_valid = 0.
  - start=1 with len!=0: acc <- 0, sat_flags <- 0, remaining <- len, go to ACCUM next cycle.
  - start=1 with len==0: acc <- 0, sat_flags <- 0, go to DONE.
- ACCUM:
  - in_ready = 1 (combinational from state).
  - Accept when in_valid & in_ready. For each lane i: s = acc_i + in_i (LANE_W-bit add).
  - Overflow when the operand signs are equal and the sign of s differs. Positive overflow -> 0111; negative overflow -> 1000; otherwise s.
  - Per-lane result written to acc_i. On overflow, sat_flags[i] <- 1 (sticky for the job).
  - remaining decrements on each accept. Accept with remaining==1 -> DONE next cycle.
  - No accept -> state and acc hold. The start input is ignored.
- DONE:
  - out_valid = 1, out_data = acc (registered; stable while out_valid is high).
  - Hold until out_ready=1; on that edge go to IDLE and drop out_valid.
  - in_ready = 0; start is ignored.
- Latency:
  - Result valid the cycle after the final accept. Throughput 1 word/cycle in ACCUM.
  - Minimum job = len + 2 cycles from start to IDLE with out_ready tied high.
- sat_flags stays visible after the job until the next accepted start or reset.
- Simultaneous out_ready and start in DONE: start is ignored; a new start is needed in IDLE.
- Reset asserted mid-job: immediate return to IDLE; the partial accumulation is discarded.
- remaining never wraps: ACCUM exits at 1 and the zero case bypasses ACCUM.

Decomposition:
- Shared package:
  - LANE_W, LANES constants.
  - Lane saturation constants SAT_POS = 4'b0111, SAT_NEG = 4'b1000.
  - State enum {IDLE, ACCUM, DONE}.
- Sub-module sat_lane_add (combinational, one lane):
  - Inputs a, b.
  - Outputs sum_sat, ovfl.
  - Instantiated LANES times via generate.
- The shared package constants are also reused by the existing lane adder.

Test Plan:
- Basic: start, len=2; accept 0x1234 then 0x1111 -> out_data=0x2345, sat_flags=0000, out_valid 1 cycle after the second accept.
- Positive saturation: len=2; words 0x7777, 0x1111 -> out_data=0x7777, sat_flags=1111.
- Negative saturation and mixed lanes:
  - len=2; words 0x8888, 0xFFFF -> out_data=0x8888, sat_flags=1111.
  - Separate job len=2; words 0x7F80, 0x1111 -> out_data=0x7091, sat_flags=1000.
- Handshake:
  - len=3 with in_valid toggling 1,0,1,0,1 -> exactly 3 accepts, correct sum.
  - Then out_ready low 3 cycles -> out_valid and out_data held stable, transition to IDLE on the first out_ready high.
- Edge cases:
  - len=0 -> DONE with out_data=0x0000 and no in_ready pulse.
  - start pulsed during ACCUM -> ignored.
  - rst_n low mid-ACCUM -> all outputs zero immediately, IDLE.
  - Next job sums from zero with cleared flags.

Source files
------------

// File: rtl/sat_lane_accum_pkg.sv
// Purpose: shared lane geometry, saturation limits and FSM encoding for the
//          packed lane adder and the lane accumulator.
// Latency: n/a (declarations only).  Backpressure: n/a.
package sat_lane_accum_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 4;
  localparam int CNT_W  = 4;

  // Signed lane clamp values: most positive / most negative two's complement.
  localparam logic [LANE_W-1:0] SAT_POS = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] SAT_NEG = {1'b1, {(LANE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sat_lane_add.sv
// Purpose: one signed lane add with saturation to the lane's min/max value.
// Latency: combinational.  Backpressure: none.
// Ports: a, b (lane operands) -> sum_sat (clamped sum), ovfl (clamp applied).
module sat_lane_add #(
  parameter int W = sat_lane_accum_pkg::LANE_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum_sat,
  output logic         ovfl
);

  localparam logic [W-1:0] LIM_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] LIM_NEG = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0] sum_raw;

  assign sum_raw = a + b;

  always_comb begin
    // Only like-signed operands can overflow; the wrapped sum flips sign.
    ovfl    = (a[W-1] == b[W-1]) && (sum_raw[W-1] != a[W-1]);
    sum_sat = sum_raw;
    if (ovfl) begin
      sum_sat = a[W-1] ? LIM_NEG : LIM_POS;
    end
  end

endmodule

// File: rtl/sat_lane_accum.sv
// Purpose: accumulate len packed lane words with per-lane signed saturation.
// Latency: result valid the cycle after the final accept; len+2 cycles minimum.
// Backpressure: in_ready only in ACCUM; result held in DONE until out_ready.
// Ports: start/len launch a job in IDLE; in_valid/in_ready/in_data word
//        stream; out_valid/out_ready/out_data result; sat_flags sticky
//        per-lane saturation; busy = not IDLE.
module sat_lane_accum #(
  parameter int LANES  = sat_lane_accum_pkg::LANES,
  parameter int LANE_W = sat_lane_accum_pkg::LANE_W,
  parameter int CNT_W  = sat_lane_accum_pkg::CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CNT_W-1:0]        len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic [LANES-1:0]        sat_flags,
  output logic                    busy
);

  import sat_lane_accum_pkg::*;

  state_e                  state_q, state_d;
  logic [LANES*LANE_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        rem_q, rem_d;
  logic [LANES-1:0]        sat_q, sat_d;

  logic [LANES*LANE_W-1:0] sum_w;
  logic [LANES-1:0]        ovfl_w;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sat_lane_add #(.W(LANE_W)) u_add (
      .a       (acc_q[i*LANE_W +: LANE_W]),
      .b       (in_data[i*LANE_W +: LANE_W]),
      .sum_sat (sum_w[i*LANE_W +: LANE_W]),
      .ovfl    (ovfl_w[i])
    );
  end

  // Handshake outputs decode straight from state so an async reset clears
  // them immediately.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = acc_q;
  assign sat_flags = sat_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    sat_d   = sat_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          sat_d = '0;
          if (len != '0) begin
            rem_d   = len;
            state_d = ACCUM;
          end else begin
            // Empty job skips ACCUM so remaining never has to count from 0.
            state_d = DONE;
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = sum_w;
          sat_d = sat_q | ovfl_w;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      sat_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_sat_lane_accum.sv
// Purpose: self-checking bench for sat_lane_accum against an integer lane model.
// Latency: n/a.  Backpressure: exercises gapped input and stalled output.
module tb_sat_lane_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  len = 4'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [3:0]  sat_flags;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] words[$];
  int          acc_m[4];
  logic [3:0]  flags_m;

  sat_lane_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat_flags (sat_flags),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Reference: lanes as plain integers, clamped to the signed 4-bit range.
  task automatic model_clear();
    for (int i = 0; i < 4; i++) acc_m[i] = 0;
    flags_m = 4'b0000;
  endtask

  task automatic model_add(input logic [15:0] w);
    logic [3:0] nib;
    int bv, s;
    for (int i = 0; i < 4; i++) begin
      nib = w[i*4 +: 4];
      bv  = (nib >= 4'd8) ? int'(nib) - 16 : int'(nib);
      s   = acc_m[i] + bv;
      if (s > 7) begin
        s = 7;
        flags_m[i] = 1'b1;
      end else if (s < -8) begin
        s = -8;
        flags_m[i] = 1'b1;
      end
      acc_m[i] = s;
    end
  endtask

  function automatic logic [15:0] model_data();
    logic [15:0] e;
    int v;
    e = 16'h0;
    for (int i = 0; i < 4; i++) begin
      v = acc_m[i];
      e[i*4 +: 4] = v[3:0];
    end
    return e;
  endfunction

  // Called #1 after a rising edge with the DUT idle; words[] holds the job.
  // vmode: 0 valid every cycle, 1 toggling from 1, 2 random.
  task automatic run_job(input int n, input int vmode, input int hold, input bit poke);
    int cnt, cyc;
    bit v;
    logic [15:0] exp_d;
    check("idle_busy", 32'(busy), 32'(0));
    check("idle_in_ready", 32'(in_ready), 32'(0));
    check("idle_out_valid", 32'(out_valid), 32'(0));
    start = 1'b1;
    len   = 4'(n);
    @(posedge clk); #1;
    start = 1'b0;
    len   = 4'd0;
    model_clear();
    cnt = 0;
    cyc = 0;
    while (cnt < n) begin
      check("accum_in_ready", 32'(in_ready), 32'(1));
      check("accum_out_valid", 32'(out_valid), 32'(0));
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom % 3) != 0;
      endcase
      in_valid = v;
      in_data  = v ? words[cnt] : 16'($urandom);
      if (poke) begin
        start = 1'($urandom);
        len   = 4'($urandom);
      end
      @(posedge clk); #1;
      if (v) begin
        model_add(words[cnt]);
        cnt++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      len      = 4'd0;
      cyc++;
      if (cyc > 200) begin
        check("accum_timeout", 32'(cnt), 32'(n));
        break;
      end
    end
    exp_d = model_data();
    check("done_out_valid", 32'(out_valid), 32'(1));
    check("done_in_ready", 32'(in_ready), 32'(0));
    check("done_busy", 32'(busy), 32'(1));
    check("done_out_data", 32'(out_data), 32'(exp_d));
    check("done_sat_flags", 32'(sat_flags), 32'(flags_m));
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      @(posedge clk); #1;
      check("stall_out_valid", 32'(out_valid), 32'(1));
      check("stall_out_data", 32'(out_data), 32'(exp_d));
    end
    out_ready = 1'b1;
    start     = poke;
    len       = 4'd3;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    len       = 4'd0;
    check("drain_out_valid", 32'(out_valid), 32'(0));
    check("drain_busy", 32'(busy), 32'(0));
    check("drain_flags_visible", 32'(sat_flags), 32'(flags_m));
    @(posedge clk); #1;
    check("post_idle_busy", 32'(busy), 32'(0));
  endtask

  task automatic directed(input logic [15:0] w0, input logic [15:0] w1,
                          input logic [15:0] exp_d, input logic [3:0] exp_f);
    words = {w0, w1};
    run_job(2, 0, 0, 1'b0);
    check("dir_out_data", 32'(out_data), 32'(exp_d));
    check("dir_sat_flags", 32'(sat_flags), 32'(exp_f));
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_sat_flags", 32'(sat_flags), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fixed-answer jobs; the held result after drain is the job total.
    directed(16'h1234, 16'h1111, 16'h2345, 4'b0000);
    directed(16'h7777, 16'h1111, 16'h7777, 4'b1111);
    directed(16'h8888, 16'hFFFF, 16'h8888, 4'b1111);
    directed(16'h7F80, 16'h1111, 16'h7091, 4'b1000);

    // Gapped input (1,0,1,0,1) then a three-cycle output stall.
    words = {16'h1203, 16'h2121, 16'h0311};
    run_job(3, 1, 3, 1'b0);

    // Empty job goes straight to DONE with a zero result.
    words = {};
    run_job(0, 0, 1, 1'b0);
    check("len0_out_data", 32'(out_data), 32'(0));

    // Start pulses during ACCUM and alongside out_ready in DONE.
    words = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    run_job(4, 2, 1, 1'b1);

    // Reset in the middle of a job.
    start = 1'b1;
    len   = 4'd5;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h7777;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("mid_sat_set", 32'(sat_flags), 32'(4'b1111));
    rst_n = 1'b0;
    #2;
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_in_ready", 32'(in_ready), 32'(0));
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_out_data", 32'(out_data), 32'(0));
    check("midrst_sat_flags", 32'(sat_flags), 32'(0));
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Next job starts from zero with clear flags.
    directed(16'h1234, 16'h1111, 16'h2345, 4'b0000);

    // Randomized jobs against the integer model.
    for (int j = 0; j < 25; j++) begin
      int n;
      n = $urandom_range(0, 15);
      words = {};
      for (int k = 0; k < n; k++) begin
        if ($urandom % 4 == 0) words.push_back(($urandom % 2) ? 16'h7777 : 16'h8888);
        else words.push_back(16'($urandom));
      end
      run_job(n, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
